alu_exec_unit: RTL and testbench

- Parametrised successor to the combinational ALU decoder.
- Decodes ALU_Op/func3/func7 and executes the operation, covering the full RV32I ALU and branch-compare set.
- Adds a valid/ready handshake, a registered result and an iterative multi-cycle shifter.
- Sits between register-file read and writeback/branch logic; lets the core stall on multi-cycle ops.

---
 rtl/alu_exec_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I ALU / branch-compare execution unit with a valid/ready
// handshake, a registered result and an iterative multi-cycle shifter.
// Optional feature: define ALU_MUL_EN to add a radix-2 shift-add multiplier
// (R-type func7=0000001, func3=000). Without it that encoding is illegal.
module alu_exec_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALU_Op,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic            op_imm,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            branch_taken,
  output logic            illegal
);

  localparam int SW  = $clog2(XLEN);
  localparam int SW1 = SW + 1;
  localparam logic [SW:0] STEP = SW1'(SHIFT_STEP);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND, K_MUL
  } kind_t;

  // One shifter step; the arithmetic variant refills with the sign bit.
  function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] v,
                                               input logic [SW:0] amt,
                                               input kind_t k);
    logic signed [XLEN-1:0] vs;
    vs = v;
    case (k)
      K_SLL:   return v << amt;
      K_SRA:   return XLEN'(vs >>> amt);
      default: return v >> amt;
    endcase
  endfunction

  state_t state, next_state, start_state;
  kind_t  kind_d, sh_kind;
  logic   ill_d, br_d, f7_live, accept, is_shift_d;
  logic   alu_zero, br_cond, shift_last;
  logic   [SW-1:0] shamt_d;
  logic   [SW:0]   sh_rem, step_amt;
  logic   [XLEN-1:0] alu_res, sh_val, sh_next;
  logic   signed [XLEN-1:0] a_s, b_s;

  assign a_s        = src_a;
  assign b_s        = src_b;
  assign shamt_d    = src_b[SW-1:0];
  assign in_ready   = (state == S_IDLE) || (state == S_DONE && out_ready);
  assign out_valid  = (state == S_DONE);
  assign accept     = in_valid && in_ready;
  assign is_shift_d = (kind_d == K_SLL) || (kind_d == K_SRL) || (kind_d == K_SRA);
  assign shift_last = (sh_rem <= STEP);
  assign step_amt   = shift_last ? sh_rem : STEP;
  assign sh_next    = shift_by(sh_val, step_amt, sh_kind);

  // Decode ALU_Op/func3/func7 into an operation kind and an illegal flag.
  always_comb begin
    kind_d  = K_ADD;
    ill_d   = 1'b0;
    br_d    = 1'b0;
    f7_live = 1'b0;
    case (ALU_Op)
      2'b00: kind_d = K_ADD;
      2'b01: begin
        br_d = 1'b1;
        case (func3)
          3'b000, 3'b001: kind_d = K_SUB;
          3'b100, 3'b101: kind_d = K_SLT;
          3'b110, 3'b111: kind_d = K_SLTU;
          default:        ill_d  = 1'b1;
        endcase
      end
      2'b10: begin
        // func7 only carries opcode bits for R-type and for immediate shifts.
        f7_live = !op_imm || (func3 == 3'b001) || (func3 == 3'b101);
        case (func3)
          3'b000:  kind_d = (!op_imm && func7 == 7'b0100000) ? K_SUB : K_ADD;
          3'b001:  kind_d = K_SLL;
          3'b010:  kind_d = K_SLT;
          3'b011:  kind_d = K_SLTU;
          3'b100:  kind_d = K_XOR;
          3'b101:  kind_d = (func7 == 7'b0100000) ? K_SRA : K_SRL;
          3'b110:  kind_d = K_OR;
          default: kind_d = K_AND;
        endcase
        if (f7_live) begin
          if (func7 == 7'b0100000) begin
            if (func3 != 3'b000 && func3 != 3'b101) ill_d = 1'b1;
          end
`ifdef ALU_MUL_EN
          else if (func7 == 7'b0000001 && !op_imm && func3 == 3'b000) begin
            kind_d = K_MUL;
          end
`endif
          else if (func7 != 7'b0000000) begin
            ill_d = 1'b1;
          end
        end
      end
      default: ill_d = 1'b1;
    endcase
  end

  // Single-cycle datapath; shifts pass src_a through (the shamt=0 case).
  always_comb begin
    alu_res = src_a;
    case (kind_d)
      K_ADD:   alu_res = src_a + src_b;
      K_SUB:   alu_res = src_a - src_b;
      K_SLT:   alu_res = {{(XLEN-1){1'b0}}, a_s < b_s};
      K_SLTU:  alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      K_XOR:   alu_res = src_a ^ src_b;
      K_OR:    alu_res = src_a | src_b;
      K_AND:   alu_res = src_a & src_b;
      default: alu_res = src_a;
    endcase
    alu_zero = (alu_res == '0);
    br_cond  = (func3[2] ? alu_res[0] : alu_zero) ^ func3[0];
  end

`ifdef ALU_MUL_EN
  logic [XLEN-1:0] acc, mcand, mplier, acc_next;
  logic [SW-1:0]   mul_cnt;
  logic            mul_last;
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (mul_cnt == SW'(XLEN - 1));

  // Shift-add multiplier: one partial product per cycle, low bits kept.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc     <= '0;
      mcand   <= src_a;
      mplier  <= src_b;
      mul_cnt <= '0;
    end else if (state == S_MUL) begin
      acc     <= acc_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      mul_cnt <= mul_cnt + 1'b1;
    end
  end
`endif

  // Next-state logic; DONE can chain straight into the next accepted op.
  always_comb begin
    start_state = S_DONE;
    if (!ill_d && is_shift_d && shamt_d != '0) start_state = S_SHIFT;
`ifdef ALU_MUL_EN
    if (!ill_d && kind_d == K_MUL) start_state = S_MUL;
`endif
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = start_state;
      S_SHIFT: if (shift_last) next_state = S_DONE;
`ifdef ALU_MUL_EN
      S_MUL:   if (mul_last) next_state = S_DONE;
`endif
      S_DONE: begin
        if (accept)         next_state = start_state;
        else if (out_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Iterative shifter working registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_val  <= src_a;
      sh_rem  <= {1'b0, shamt_d};
      sh_kind <= kind_d;
    end else if (state == S_SHIFT) begin
      sh_val  <= sh_next;
      sh_rem  <= sh_rem - step_amt;
    end
  end

  // Result/flag registers, written on accept or at the last iterative step.
  always_ff @(posedge clk) begin
    if (rst) begin
      result       <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else if (accept) begin
      result       <= ill_d ? '0 : alu_res;
      zero         <= ill_d ? 1'b1 : alu_zero;
      branch_taken <= !ill_d && br_d && br_cond;
      illegal      <= ill_d;
    end else if (state == S_SHIFT && shift_last) begin
      result       <= sh_next;
      zero         <= (sh_next == '0);
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end
`ifdef ALU_MUL_EN
    else if (state == S_MUL && mul_last) begin
      result       <= acc_next;
      zero         <= (acc_next == '0);
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized ops
// against a behavioural model. Runs SHIFT_STEP=1 and SHIFT_STEP=4 instances
// side by side on shared inputs. Honours ALU_MUL_EN like the design.
module tb_alu_exec_unit;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, op_imm;
  logic [1:0]  ALU_Op;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] src_a, src_b;
  logic        in_ready, out_valid, zero, branch_taken, illegal;
  logic [31:0] result;
  logic        in_ready4, out_valid4, zero4, branch_taken4, illegal4;
  logic [31:0] result4;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_Op(ALU_Op), .func3(func3), .func7(func7), .op_imm(op_imm),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .branch_taken(branch_taken), .illegal(illegal));

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .ALU_Op(ALU_Op), .func3(func3), .func7(func7), .op_imm(op_imm),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4), .zero(zero4), .branch_taken(branch_taken4), .illegal(illegal4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: result, flags and latency straight from the ISA rules.
  function automatic void model(input logic [1:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input bit imm,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output bit ill,
                                output bit bt, output int lat1, output int lat4);
    int sh;
    bit mul, is_sh;
    sh = int'(b[4:0]);
    res = 0; ill = 0; bt = 0; mul = 0; lat1 = 1; lat4 = 1;
    case (op)
      2'd0: res = a + b;
      2'd1: begin
        case (f3)
          3'd0: begin res = a - b; bt = (a == b); end
          3'd1: begin res = a - b; bt = (a != b); end
          3'd4: begin res = 32'($signed(a) < $signed(b)); bt = ($signed(a) < $signed(b)); end
          3'd5: begin res = 32'($signed(a) < $signed(b)); bt = !($signed(a) < $signed(b)); end
          3'd6: begin res = 32'(a < b); bt = (a < b); end
          3'd7: begin res = 32'(a < b); bt = !(a < b); end
          default: ill = 1;
        endcase
      end
      2'd2: begin
        is_sh = (f3 == 3'd1) || (f3 == 3'd5);
        if (!imm || is_sh) begin
          if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ill = 1;
          else if (MUL_EN && f7 == 7'h01 && !imm && f3 == 3'd0) mul = 1;
          else if (f7 != 7'h00 && f7 != 7'h20) ill = 1;
        end
        case (f3)
          3'd0: res = mul ? a * b : ((!imm && f7 == 7'h20) ? a - b : a + b);
          3'd1: res = a << sh;
          3'd2: res = 32'($signed(a) < $signed(b));
          3'd3: res = 32'(a < b);
          3'd4: res = a ^ b;
          3'd5: res = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: res = a | b;
          default: res = a & b;
        endcase
        if (is_sh && sh != 0) begin lat1 = sh + 1; lat4 = (sh + 3) / 4 + 1; end
        if (mul) begin lat1 = 33; lat4 = 33; end
      end
      default: ill = 1;
    endcase
    if (ill) begin res = 0; bt = 0; lat1 = 1; lat4 = 1; end
  endfunction

  // Issue one op with out_ready=1, then watch both instances for their result.
  task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input bit imm, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    bit ei, eb, g1, g4;
    int l1, l4;
    model(op, f3, f7, imm, a, b, er, ei, eb, l1, l4);
    ALU_Op = op; func3 = f3; func7 = f7; op_imm = imm; src_a = a; src_b = b;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("in_ready_accept", in_ready, 1);
    step();
    in_valid = 1'b0; src_a = $urandom; src_b = $urandom;
    g1 = 0; g4 = 0;
    for (int cyc = 1; cyc <= 40 && !(g1 && g4); cyc++) begin
      if (cyc == 1 && l1 > 1) chk("busy_in_ready", in_ready, 0);
      if (!g1 && out_valid) begin
        g1 = 1;
        chk("latency", cyc, l1);
        chk("result", result, er);
        chk("zero", zero, er == 0);
        chk("illegal", illegal, ei);
        chk("branch_taken", branch_taken, eb);
      end
      if (!g4 && out_valid4) begin
        g4 = 1;
        chk("latency_step4", cyc, l4);
        chk("result_step4", result4, er);
      end
      if (!(g1 && g4)) step();
    end
    chk("got_valid", g1, 1);
    chk("got_valid_step4", g4, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b;
    bit          imm;
    int          r;

    rst = 1'b1; in_valid = 0; out_ready = 1; op_imm = 0;
    ALU_Op = 0; func3 = 0; func7 = 0; src_a = 0; src_b = 0;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_branch", branch_taken, 0);
    chk("rst_illegal", illegal, 0);
    rst = 1'b0;
    step();

    // Directed cases
    do_op(2'd2, 3'd0, 7'h20, 0, 32'd5, 32'd7);                   // SUB -> FFFFFFFE
    do_op(2'd1, 3'd5, 7'h00, 0, 32'hFFFFFFFF, 32'd1);            // BGE not taken
    do_op(2'd1, 3'd7, 7'h00, 0, 32'hFFFFFFFF, 32'd1);            // BGEU taken
    do_op(2'd1, 3'd0, 7'h00, 0, 32'd9, 32'd9);                   // BEQ taken
    do_op(2'd2, 3'd5, 7'h20, 0, 32'h80000000, 32'd4);            // SRA -> F8000000
    do_op(2'd2, 3'd5, 7'h20, 1, 32'h80000000, 32'h20);           // SRAI shamt 0
    do_op(2'd2, 3'd1, 7'h00, 1, 32'h00000001, 32'd31);           // SLLI 31
    do_op(2'd3, 3'd0, 7'h00, 0, 32'd1, 32'd2);                   // reserved ALU_Op
    do_op(2'd2, 3'd0, 7'h02, 0, 32'd1, 32'd2);                   // bad R-type func7
    do_op(2'd2, 3'd0, 7'h01, 0, 32'hFFFFFFFF, 32'd3);            // MUL or illegal
    do_op(2'd2, 3'd4, 7'h20, 0, 32'd1, 32'd2);                   // func7 0100000 on XOR
    step();

    // Hold result while out_ready is low, then back-to-back accept
    ALU_Op = 0; func3 = 0; func7 = 0; op_imm = 0; src_a = 3; src_b = 4;
    in_valid = 1; out_ready = 0;
    step();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, 7);
      chk("hold_in_ready", in_ready, 0);
      step();
    end
    src_a = 10; src_b = 20; in_valid = 1; out_ready = 1;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    step();
    in_valid = 0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_result", result, 30);
    step();

    // Reset in the middle of a long shift
    ALU_Op = 2; func3 = 5; func7 = 0; op_imm = 1; src_a = $urandom; src_b = 31;
    in_valid = 1;
    step();
    in_valid = 0;
    repeat (9) step();
    chk("midshift_busy", in_ready, 0);
    rst = 1;
    step();
    chk("midshift_rst_valid", out_valid, 0);
    chk("midshift_rst_ready", in_ready, 1);
    chk("midshift_rst_valid4", out_valid4, 0);
    rst = 0;
    step();
    chk("post_rst_valid", out_valid, 0);

    // Randomized ops
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      f3 = 3'($urandom_range(0, 7));
      imm = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 5);
      f7 = (r < 3) ? 7'h00 : (r == 3) ? 7'h20 : (r == 4) ? 7'h01 : 7'($urandom_range(0, 127));
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 7);
      if (r == 0) a = 32'h80000000;
      else if (r == 1) a = 32'hFFFFFFFF;
      else if (r == 2) a = 32'h7FFFFFFF;
      if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
      if ($urandom_range(0, 4) == 0) b = a;
      do_op(op, f3, f7, imm, a, b);
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
